trs80_kbd_scanner: RTL
======================

Name: trs80_kbd_scanner

Overview:
- Scans a physical TRS-80 keyboard matrix and streams the corresponding ASCII/VT100 bytes toward a UART transmitter.
- Each of the 8 active-low row (address) lines is driven low in turn, the 8 active-low column (data) lines are sampled, and the result is debounced per frame.
- Newly pressed keys are encoded with the same key↔character map the keyboard emulator decodes.
- It is therefore the host-side counterpart of the emulated keyboard: it produces the byte stream the emulator consumes.

Parameters:
- SETTLE_CYCLES, 27, clk_in cycles between driving a row and sampling columns (>=2).
- FRAME_GAP, 27000, idle cycles between scan frames (1 ms at 27 MHz).
- DEBOUNCE_FRAMES, 4, consecutive identical frames required before the matrix image is accepted as stable (1..15).

Ports:
- clk_in  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- kbd_addr_n  output  8  row select; exactly one bit low while scanning, else 8'hFF.
- kbd_data_n  input  8  column returns, active-low, asynchronous.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  sink accepts when tx_valid&&tx_ready.
- key_down  output  1  any non-shift key in the stable image.

Behaviour:
- Reset values: kbd_addr_n=8'hFF, tx_data=0, tx_valid=0, key_down=0. All internal images and counters are 0; FSM state is GAP. Reset mid-frame or mid-sequence abandons the work immediately.
- kbd_data_n passes through a 2-flop synchronizer and is inverted internally (1 = pressed).
- FSM states: GAP → DRIVE → SETTLE → SAMPLE → (next row: DRIVE | row 7 done: EVAL) → EMIT → GAP.
  - GAP: kbd_addr_n=FF for FRAME_GAP cycles.
  - DRIVE: kbd_addr_n=~(1<<row).
  - SETTLE: count SETTLE_CYCLES.
  - SAMPLE: cur[row] <= synced data. The row stays driven through SAMPLE and is released on the next DRIVE/GAP.
- EVAL (1 cycle):
  - If cur==last, increment the match counter, saturating at DEBOUNCE_FRAMES; otherwise clear it. Then last<=cur.
  - When the counter reaches DEBOUNCE_FRAMES, stable<=cur.
  - reported <= reported & stable, so releases re-arm keys.
  - new = stable & ~reported, with row 7 masked.
  - If new!=0: pick the lowest index (row*8+bit), set its reported bit, and enter EMIT. Otherwise go to GAP.
  - Only one key is emitted per frame; remaining new keys are emitted on subsequent frames in ascending index order.
- Shift is stable[7][0], captured at EVAL.
- Encoding, unshifted / shifted:
  - row0 b0..7: '@','A'..'G' / '`'?no: '@'..'G' / 'a'..'g' (bit0 shifted = '`').
  - row1: 'H'..'O' / 'h'..'o'.
  - row2: 'P'..'W' / 'p'..'w'.
  - row3 b0..2: 'X','Y','Z' / 'x','y','z'; b3..7 are ignored (no emit, bit still marked reported).
  - row4: '0'..'7' / '^','!','"','#','$','%','&','\''.
  - row5: '8','9',':',';',',','-','.','/' / '(',')','*','+','<','=','>','?'.
  - row6 (shift ignored): b0 0x0D, b1 '~', b2 '`', b3 ESC '[' 'A', b4 ESC '[' 'B', b5 ESC '[' 'D', b6 ESC '[' 'C', b7 ' '.
- EMIT:
  - Sequences are 1 or 3 bytes.
  - tx_valid=1 with tx_data held stable until tx_ready. Transfer occurs on the cycle valid&&ready.
  - The next byte is presented on the following cycle.
  - tx_valid drops the cycle after the last transfer, then the FSM enters GAP.
  - Scanning is suspended during EMIT; kbd_addr_n=FF.
  - tx_ready tied high gives 1 byte per cycle.
- key_down = |stable[6:0] | |stable[7][7:1], registered, updated at EVAL.
- Simultaneous press of two keys in one stable frame: the lower index is emitted first; the other follows the next frame.
- A held key never repeats until it is released and re-debounced.
- Ghosting is not suppressed.

Decomposition:
- Package trs80_kbd_pkg:
  - FSM state enum.
  - KEY_SHIFT_ROW/BIT.
  - Row-6 special-key indices.
  - ASCII constants ESC=8'h1B, CR=8'h0D.
  - Function key_index(row,bit).
- Sub-module trs80_key_encoder (combinational): key index + shift → {len[1:0], b0, b1, b2}, with len=0 meaning ignore.
- Scanner FSM, debounce and handshake remain in trs80_kbd_scanner.

Test Plan:
1. Reset, then hold 'A' (row0 b1) low for 10 frames, tx_ready=1 → exactly one byte 0x41 after frame DEBOUNCE_FRAMES+1. kbd_addr_n only ever drives patterns FE,FD,…,7F,FF.
2. Hold shift (row7 b0) plus '3' (row4 b3) → single byte 0x23 ('#'). Shift alone → no output, key_down=0.
3. Press up arrow (row6 b3) with tx_ready toggling 1-of-3 cycles → bytes 1B,5B,41 in order, tx_data stable while valid&&!ready, tx_valid deasserted after 0x41.
4. Bounce 'Z' (row3 b2) alternating every frame for 6 frames, then hold → no output during bounce; one 0x5A after DEBOUNCE_FRAMES stable frames. Release and re-press → second 0x5A.
5. Press '8' (row5 b0) and space (row6 b7) in the same frame → 0x38 then 0x20 on the next frame; holding both for 20 frames produces no further bytes.
6. Assert reset during EMIT after byte 0x1B → tx_valid=0 and kbd_addr_n=FF the next cycle, with no further bytes until a new press is debounced.

Source files
------------

// File: rtl/trs80_kbd_pkg.sv
// rtl/trs80_kbd_pkg.sv - shared types and key constants for the TRS-80 keyboard scanner
package trs80_kbd_pkg;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_EMIT
    } scan_state_t;

    typedef struct packed {
        logic [1:0] len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } key_seq_t;

    localparam logic [2:0] KEY_SHIFT_ROW = 3'd7;
    localparam logic [2:0] KEY_SHIFT_BIT = 3'd0;

    localparam logic [5:0] KEY_CR     = 6'd48;
    localparam logic [5:0] KEY_TILDE  = 6'd49;
    localparam logic [5:0] KEY_BQUOTE = 6'd50;
    localparam logic [5:0] KEY_UP     = 6'd51;
    localparam logic [5:0] KEY_DOWN   = 6'd52;
    localparam logic [5:0] KEY_LEFT   = 6'd53;
    localparam logic [5:0] KEY_RIGHT  = 6'd54;
    localparam logic [5:0] KEY_SPACE  = 6'd55;

    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_CR  = 8'h0D;

    function automatic logic [5:0] key_index(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

    localparam logic [5:0] KEY_SHIFT_POS = key_index(KEY_SHIFT_ROW, KEY_SHIFT_BIT);

endpackage

// File: rtl/trs80_key_encoder.sv
// rtl/trs80_key_encoder.sv - maps a matrix key index plus shift to a 1- or 3-byte sequence
module trs80_key_encoder
    import trs80_kbd_pkg::*;
(
    input  logic [5:0] key_idx,
    input  logic       shift,
    output key_seq_t   seq
);

    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] punct;

    assign row = key_idx[5:3];
    assign col = key_idx[2:0];

    // Row 5 splits into 0x38.. and 0x2C.. halves; shifting flips bit 4 of either half.
    assign punct = col[2] ? {5'b00101, col} : {5'b00111, col};

    always_comb begin
        seq = '0;
        case (row)
            3'd0, 3'd1, 3'd2: begin
                seq.len = 2'd1;
                seq.b0  = (shift ? 8'h60 : 8'h40) + {2'b00, key_idx};
            end
            3'd3: begin
                if (col < 3'd3) begin
                    seq.len = 2'd1;
                    seq.b0  = (shift ? 8'h60 : 8'h40) + {2'b00, key_idx};
                end
            end
            3'd4: begin
                seq.len = 2'd1;
                if (!shift)
                    seq.b0 = {5'b00110, col};
                else if (col == 3'd0)
                    seq.b0 = 8'h5E;
                else
                    seq.b0 = {5'b00100, col};
            end
            3'd5: begin
                seq.len = 2'd1;
                seq.b0  = shift ? (punct ^ 8'h10) : punct;
            end
            3'd6: begin
                seq.len = 2'd1;
                case (key_idx)
                    KEY_CR:     seq.b0 = ASCII_CR;
                    KEY_TILDE:  seq.b0 = 8'h7E;
                    KEY_BQUOTE: seq.b0 = 8'h60;
                    KEY_SPACE:  seq.b0 = 8'h20;
                    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT: begin
                        seq.len = 2'd3;
                        seq.b0  = ASCII_ESC;
                        seq.b1  = 8'h5B;
                        case (key_idx)
                            KEY_UP:   seq.b2 = 8'h41;
                            KEY_DOWN: seq.b2 = 8'h42;
                            KEY_LEFT: seq.b2 = 8'h44;
                            default:  seq.b2 = 8'h43;
                        endcase
                    end
                    default: seq.len = 2'd0;
                endcase
            end
            default: seq.len = 2'd0;
        endcase
    end

endmodule

// File: rtl/trs80_kbd_scanner.sv
// rtl/trs80_kbd_scanner.sv - scans the TRS-80 key matrix, debounces per frame and streams key bytes
module trs80_kbd_scanner
    import trs80_kbd_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 27,
    parameter int FRAME_GAP       = 27000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic [7:0] kbd_addr_n,
    input  logic [7:0] kbd_data_n,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       key_down
);

    localparam int GAP_W = $clog2(FRAME_GAP + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

    scan_state_t  state;
    logic [GAP_W-1:0] gap_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [2:0]   row;
    logic [7:0]   sync1;
    logic [7:0]   sync2;
    logic [63:0]  cur;
    logic [63:0]  last;
    logic [63:0]  stable;
    logic [63:0]  reported;
    logic [3:0]   match_cnt;
    logic [1:0]   seq_len_r;
    logic [7:0]   seq_b1_r;
    logic [7:0]   seq_b2_r;
    logic [1:0]   byte_idx;

    logic [3:0]   match_nxt;
    logic [63:0]  stable_nxt;
    logic [63:0]  rep_masked;
    logic [63:0]  new_keys;
    logic         pick_found;
    logic [5:0]   pick_idx;
    logic         key_down_nxt;
    key_seq_t     enc_seq;

    always_comb begin
        match_nxt = 4'd0;
        if (cur == last)
            match_nxt = (match_cnt >= DEB) ? DEB : match_cnt + 4'd1;
        stable_nxt = (match_nxt == DEB) ? cur : stable;
        rep_masked = reported & stable_nxt;
        new_keys   = stable_nxt & ~rep_masked;
        new_keys[63:56] = 8'h00;
        key_down_nxt = (|stable_nxt[55:0]) | (|stable_nxt[63:57]);
        // Descending scan so the lowest set index is the one left standing.
        pick_found = 1'b0;
        pick_idx   = 6'd0;
        for (int i = 55; i >= 0; i--) begin
            if (new_keys[i]) begin
                pick_found = 1'b1;
                pick_idx   = 6'(i);
            end
        end
    end

    trs80_key_encoder u_encoder (
        .key_idx (pick_idx),
        .shift   (stable_nxt[KEY_SHIFT_POS]),
        .seq     (enc_seq)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= ST_GAP;
            gap_cnt    <= '0;
            settle_cnt <= '0;
            row        <= 3'd0;
            sync1      <= 8'h00;
            sync2      <= 8'h00;
            cur        <= '0;
            last       <= '0;
            stable     <= '0;
            reported   <= '0;
            match_cnt  <= 4'd0;
            seq_len_r  <= 2'd0;
            seq_b1_r   <= 8'h00;
            seq_b2_r   <= 8'h00;
            byte_idx   <= 2'd0;
            kbd_addr_n <= 8'hFF;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            key_down   <= 1'b0;
        end else begin
            sync1 <= ~kbd_data_n;
            sync2 <= sync1;
            case (state)
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
                        gap_cnt    <= '0;
                        row        <= 3'd0;
                        kbd_addr_n <= 8'hFE;
                        state      <= ST_DRIVE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYCLES - 1))
                        state <= ST_SAMPLE;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    cur[key_index(row, 3'd0) +: 8] <= sync2;
                    if (row == 3'd7) begin
                        kbd_addr_n <= 8'hFF;
                        state      <= ST_EVAL;
                    end else begin
                        row        <= row + 3'd1;
                        kbd_addr_n <= ~(8'h01 << (row + 3'd1));
                        state      <= ST_DRIVE;
                    end
                end
                ST_EVAL: begin
                    match_cnt <= match_nxt;
                    last      <= cur;
                    stable    <= stable_nxt;
                    key_down  <= key_down_nxt;
                    gap_cnt   <= '0;
                    state     <= ST_GAP;
                    if (pick_found) begin
                        // Ignored keys are still marked so they never block later keys.
                        reported <= rep_masked | (64'd1 << pick_idx);
                        if (enc_seq.len != 2'd0) begin
                            seq_len_r <= enc_seq.len;
                            seq_b1_r  <= enc_seq.b1;
                            seq_b2_r  <= enc_seq.b2;
                            tx_data   <= enc_seq.b0;
                            tx_valid  <= 1'b1;
                            byte_idx  <= 2'd0;
                            state     <= ST_EMIT;
                        end
                    end else begin
                        reported <= rep_masked;
                    end
                end
                ST_EMIT: begin
                    if (tx_valid && tx_ready) begin
                        if (byte_idx == seq_len_r - 2'd1) begin
                            tx_valid <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= ST_GAP;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_data  <= (byte_idx == 2'd0) ? seq_b1_r : seq_b2_r;
                        end
                    end
                end
                default: state <= ST_GAP;
            endcase
        end
    end

endmodule
